// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one HI/LO-path operation at a time.
// MULT and DIV are handed to external multicycle units through a
// level-sensitive start signal. Their results land in the architectural
// HI/LO registers. MTHI/MTLO and divide-by-zero finish in a single cycle
// without engaging a unit. A run counter abandons an operation whose
// unit never reports a result.
module muldiv_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        op_ack,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic        timeout_err,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_ctrl,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic        div_out,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   output logic        mult_ctrl,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   input  logic        mult_out,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo
);

   localparam int DATA_W = 32;

   localparam logic [2:0] OP_MULT = 3'b001;
   localparam logic [2:0] OP_DIV  = 3'b010;
   localparam logic [2:0] OP_MTHI = 3'b011;
   localparam logic [2:0] OP_MTLO = 3'b100;

   // Last RUN cycle index; reaching it without a result abandons the op.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN_MULT = 2'd1,
      S_RUN_DIV  = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   state_t              state_q,  state_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [DATA_W-1:0]   hi_q,     hi_d;
   logic [DATA_W-1:0]   lo_q,     lo_d;
   logic [DATA_W-1:0]   div_a_q,  div_a_d;
   logic [DATA_W-1:0]   div_b_q,  div_b_d;
   logic [DATA_W-1:0]   mul_a_q,  mul_a_d;
   logic [DATA_W-1:0]   mul_b_q,  mul_b_d;
   logic                done_q,   done_d;
   logic                dz_q,     dz_d;
   logic                terr_q,   terr_d;

   logic                op_legal;
   logic                unit_out;
   logic [DATA_W-1:0]   unit_hi;
   logic                unit_lo_sel;

   // Decode which op codes are real operations; everything else is a no-op.
   always_comb begin
      op_legal = 1'b0;
      case (op_code)
         OP_MULT, OP_DIV, OP_MTHI, OP_MTLO: op_legal = 1'b1;
         default:                          op_legal = 1'b0;
      endcase
   end

   assign op_ack = op_valid & (state_q == S_IDLE) & op_legal;

   // Select the result interface of whichever unit is currently running.
   always_comb begin
      unit_out    = 1'b0;
      unit_hi     = '0;
      unit_lo_sel = 1'b0;
      if (state_q == S_RUN_MULT) begin
         unit_out    = mult_out;
         unit_hi     = mult_hi;
         unit_lo_sel = 1'b0;
      end else if (state_q == S_RUN_DIV) begin
         unit_out    = div_out;
         unit_hi     = div_hi;
         unit_lo_sel = 1'b1;
      end
   end

   // Next-state, operand latching, HI/LO update and status pulse generation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      div_a_d = div_a_q;
      div_b_d = div_b_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      terr_d  = terr_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (op_ack) begin
               case (op_code)
                  OP_MULT: begin
                     mul_a_d = rs_val;
                     mul_b_d = rt_val;
                     state_d = S_RUN_MULT;
                  end
                  OP_DIV: begin
                     // A zero divisor never reaches the divider: report and stay idle.
                     if (rt_val == '0) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                     end else begin
                        div_a_d = rs_val;
                        div_b_d = rt_val;
                        state_d = S_RUN_DIV;
                     end
                  end
                  OP_MTHI: begin
                     hi_d   = rs_val;
                     done_d = 1'b1;
                  end
                  OP_MTLO: begin
                     lo_d   = rs_val;
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         S_RUN_MULT, S_RUN_DIV: begin
            // A result arriving on the last allowed cycle still counts as success.
            if (unit_out) begin
               hi_d    = unit_hi;
               lo_d    = unit_lo_sel ? div_lo : mult_lo;
               done_d  = 1'b1;
               state_d = S_RELEASE;
            end else if (cnt_q == CNT_LAST) begin
               terr_d  = 1'b1;
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_RELEASE: begin
            // One cycle with both starts low so the unit can re-arm.
            cnt_d   = '0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything, including HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         div_a_q <= '0;
         div_b_q <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         div_a_q <= div_a_d;
         div_b_q <= div_b_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         terr_q  <= terr_d;
      end
   end

   // Start levels come straight from the state, so they can never overlap.
   assign mult_ctrl    = (state_q == S_RUN_MULT);
   assign div_ctrl     = (state_q == S_RUN_DIV);
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign div_zero     = dz_q;
   assign timeout_err  = terr_q;
   assign hi           = hi_q;
   assign lo           = lo_q;
   assign div_dividend = div_a_q;
   assign div_divisor  = div_b_q;
   assign mult_a       = mul_a_q;
   assign mult_b       = mul_b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with small behavioural divider and
// multiplier models attached to the unit interfaces.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] rs_val, rt_val;
   logic        op_ack, busy, done, div_zero, timeout_err;
   logic [31:0] hi, lo;
   logic        div_ctrl, div_out;
   logic [31:0] div_dividend, div_divisor, div_hi, div_lo;
   logic        mult_ctrl, mult_out;
   logic [31:0] mult_a, mult_b, mult_hi, mult_lo;

   int tests_run = 0;
   int fails = 0;

   // Divider model: result valid once the start level has been high 34 cycles.
   int div_cnt = 0;
   // Multiplier model: result valid after 3 cycles, unless disabled.
   int mult_cnt = 0;
   logic mult_en = 1'b1;
   logic [63:0] prod;

   muldiv_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .rs_val(rs_val), .rt_val(rt_val), .op_ack(op_ack), .busy(busy),
      .done(done), .div_zero(div_zero), .timeout_err(timeout_err),
      .hi(hi), .lo(lo),
      .div_ctrl(div_ctrl), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_out(div_out), .div_hi(div_hi), .div_lo(div_lo),
      .mult_ctrl(mult_ctrl), .mult_a(mult_a), .mult_b(mult_b),
      .mult_out(mult_out), .mult_hi(mult_hi), .mult_lo(mult_lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      div_cnt  <= div_ctrl  ? div_cnt + 1  : 0;
      mult_cnt <= mult_ctrl ? mult_cnt + 1 : 0;
   end

   assign div_out  = div_ctrl && (div_cnt >= 34);
   assign div_hi   = (div_divisor != 0) ? div_dividend % div_divisor : 32'h0;
   assign div_lo   = (div_divisor != 0) ? div_dividend / div_divisor : 32'h0;
   assign prod     = {32'h0, mult_a} * {32'h0, mult_b};
   assign mult_out = mult_ctrl && mult_en && (mult_cnt >= 3);
   assign mult_hi  = prod[63:32];
   assign mult_lo  = prod[31:0];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; op_valid = 1'b0; op_code = 3'b000; rs_val = '0; rt_val = '0;
      step(); step();
      tests_run++;
      if ({hi, lo} !== 64'h0) begin
         fails++; $display("FAIL reset_hilo: got %h_%h, expected 0_0", hi, lo);
      end
      tests_run++;
      if ({busy, done, div_zero, timeout_err, div_ctrl, mult_ctrl} !== 6'b0) begin
         fails++; $display("FAIL reset_ctl: got %b%b%b%b%b%b, expected 000000",
                           busy, done, div_zero, timeout_err, div_ctrl, mult_ctrl);
      end
      tests_run++;
      if ({div_dividend, div_divisor, mult_a, mult_b} !== 128'h0) begin
         fails++; $display("FAIL reset_operands: got nonzero operand latch");
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_div();
      int n = 0, rel = 0, dn = 0, both = 0, dz = 0;
      op_valid = 1'b1; op_code = 3'b010; rs_val = 32'd100; rt_val = 32'd7;
      #1;
      tests_run++;
      if (op_ack !== 1'b1) begin
         fails++; $display("FAIL div_ack: got %b, expected 1", op_ack);
      end
      step();
      op_valid = 1'b0;
      while (busy === 1'b1 && n < 200) begin
         if (!div_ctrl) rel++;
         if (done) dn++;
         if (div_zero) dz++;
         if (div_ctrl && mult_ctrl) both++;
         n++;
         step();
      end
      tests_run++;
      if (n !== 36) begin
         fails++; $display("FAIL div_busy_len: got %0d, expected 36", n);
      end
      tests_run++;
      if (rel !== 1 || dn !== 1 || dz !== 0 || both !== 0) begin
         fails++; $display("FAIL div_pulses: got rel=%0d done=%0d dz=%0d both=%0d, expected 1 1 0 0",
                           rel, dn, dz, both);
      end
      tests_run++;
      if (hi !== 32'd2 || lo !== 32'd14) begin
         fails++; $display("FAIL div_result: got hi=%h lo=%h, expected 2 e", hi, lo);
      end
   endtask

   task automatic test_div_zero();
      op_valid = 1'b1; op_code = 3'b010; rs_val = 32'hFFFF_FFF9; rt_val = 32'h0;
      #1;
      tests_run++;
      if (op_ack !== 1'b1) begin
         fails++; $display("FAIL dz_ack: got %b, expected 1", op_ack);
      end
      step();
      op_valid = 1'b0;
      tests_run++;
      if ({done, div_zero, busy, div_ctrl} !== 4'b1100) begin
         fails++; $display("FAIL dz_pulse: got %b%b%b%b, expected 1100", done, div_zero, busy, div_ctrl);
      end
      tests_run++;
      if (hi !== 32'd2 || lo !== 32'd14) begin
         fails++; $display("FAIL dz_hilo: got hi=%h lo=%h, expected 2 e", hi, lo);
      end
      step();
      tests_run++;
      if ({done, div_zero, busy, div_ctrl} !== 4'b0000) begin
         fails++; $display("FAIL dz_after: got %b%b%b%b, expected 0000", done, div_zero, busy, div_ctrl);
      end
   endtask

   task automatic test_mt();
      op_valid = 1'b1; op_code = 3'b011; rs_val = 32'hDEAD_BEEF; rt_val = '0;
      step();
      op_code = 3'b100; rs_val = 32'h1234_5678;
      tests_run++;
      if (hi !== 32'hDEAD_BEEF || done !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL mthi: got hi=%h done=%b busy=%b, expected deadbeef 1 0", hi, done, busy);
      end
      #1;
      tests_run++;
      if (op_ack !== 1'b1) begin
         fails++; $display("FAIL mtlo_ack: got %b, expected 1", op_ack);
      end
      step();
      op_valid = 1'b0;
      tests_run++;
      if (lo !== 32'h1234_5678 || hi !== 32'hDEAD_BEEF || done !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL mtlo: got hi=%h lo=%h done=%b busy=%b, expected deadbeef 12345678 1 0",
                           hi, lo, done, busy);
      end
      step();
      tests_run++;
      if (done !== 1'b0) begin
         fails++; $display("FAIL mt_done_clear: got %b, expected 0", done);
      end
   endtask

   task automatic test_mult_hold();
      int n = 0, acks = 0, dn = 0;
      mult_en = 1'b1;
      op_valid = 1'b1; op_code = 3'b001; rs_val = 32'h0001_0000; rt_val = 32'h0001_0000;
      step();
      // A DIV request held throughout the run must not be acknowledged.
      op_code = 3'b010; rs_val = 32'd9; rt_val = 32'd3;
      #1;
      while (busy === 1'b1 && n < 200) begin
         if (op_ack) acks++;
         if (done) dn++;
         n++;
         step();
      end
      tests_run++;
      if (n !== 5 || acks !== 0 || dn !== 1) begin
         fails++; $display("FAIL mult_run: got busy=%0d acks=%0d done=%0d, expected 5 0 1", n, acks, dn);
      end
      tests_run++;
      if (op_ack !== 1'b1) begin
         fails++; $display("FAIL mult_idle_ack: got %b, expected 1", op_ack);
      end
      op_valid = 1'b0;
      #1;
      tests_run++;
      if (hi !== 32'h1 || lo !== 32'h0) begin
         fails++; $display("FAIL mult_result: got hi=%h lo=%h, expected 1 0", hi, lo);
      end
   endtask

   task automatic test_timeout();
      int n = 0, dn = 0;
      mult_en = 1'b0;
      op_valid = 1'b1; op_code = 3'b001; rs_val = 32'd5; rt_val = 32'd6;
      step();
      op_valid = 1'b0;
      while (mult_ctrl === 1'b1 && n < 200) begin
         if (done) dn++;
         n++;
         step();
      end
      tests_run++;
      if (n !== 64) begin
         fails++; $display("FAIL to_len: got %0d, expected 64", n);
      end
      tests_run++;
      if ({timeout_err, busy, done, dn[0]} !== 4'b1100 || hi !== 32'h1 || lo !== 32'h0) begin
         fails++; $display("FAIL to_release: got err=%b busy=%b done=%b hi=%h lo=%h, expected 1 1 0 1 0",
                           timeout_err, busy, done, hi, lo);
      end
      step();
      op_valid = 1'b1; op_code = 3'b011; rs_val = 32'hCAFE_F00D;
      step();
      op_valid = 1'b0;
      tests_run++;
      if (hi !== 32'hCAFE_F00D || done !== 1'b1 || timeout_err !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL to_then_mthi: got hi=%h done=%b err=%b busy=%b, expected cafef00d 1 1 0",
                           hi, done, timeout_err, busy);
      end
      mult_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int n = 0;
      op_valid = 1'b1; op_code = 3'b010; rs_val = 32'd100; rt_val = 32'd7;
      step();
      op_valid = 1'b0;
      for (int i = 1; i < 10; i++) step();
      reset = 1'b1;
      step();
      tests_run++;
      if ({busy, done, div_zero, timeout_err, div_ctrl, mult_ctrl} !== 6'b0 ||
          {hi, lo, div_dividend, div_divisor} !== 128'h0) begin
         fails++; $display("FAIL reset_mid: got busy=%b err=%b dctl=%b hi=%h lo=%h dvd=%h, expected all 0",
                           busy, timeout_err, div_ctrl, hi, lo, div_dividend);
      end
      reset = 1'b0;
      op_valid = 1'b1; op_code = 3'b010; rs_val = 32'd9; rt_val = 32'd3;
      step();
      op_valid = 1'b0;
      while (done !== 1'b1 && n < 200) begin
         n++;
         step();
      end
      tests_run++;
      if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd3) begin
         fails++; $display("FAIL div_9_3: got done=%b hi=%h lo=%h, expected 1 0 3", done, hi, lo);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_div();
      test_div_zero();
      test_mt();
      test_mult_hold();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencing controller for the multicycle divider and multiplier in the HI/LO execute path. Accepts one mult/div/move-to-HI/LO operation at a time from the main control unit. Drives the level-sensitive start of the selected unit, captures its HI/LO results into the architectural HI/LO registers, and reports busy, completion, divide-by-zero and timeout to the control unit.

Parameters:
TIMEOUT, 64, maximum RUN cycles before the operation is abandoned (must be > 34)
CNT_W, 7, width of the run-cycle counter (holds TIMEOUT)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  operation request from control unit
op_code  in  3  001 MULT, 010 DIV, 011 MTHI, 100 MTLO; all others are no-op
rs_val  in  32  operand A / dividend / move source
rt_val  in  32  operand B / divisor
op_ack  out  1  combinational: op_valid & state==IDLE & op_code legal
busy  out  1  high in RUN_MULT, RUN_DIV, RELEASE
done  out  1  one-cycle pulse when an accepted op finishes (incl. div-by-zero)
div_zero  out  1  one-cycle pulse, coincident with done, DIV with rt_val==0
timeout_err  out  1  sticky until reset
hi  out  32  architectural HI register
lo  out  32  architectural LO register
div_ctrl  out  1  divider start level
div_dividend  out  32  latched rs_val
div_divisor  out  32  latched rt_val
div_out  in  1  divider result-valid
div_hi  in  32  divider remainder
div_lo  in  32  divider quotient
mult_ctrl  out  1  multiplier start level
mult_a  out  32  latched rs_val
mult_b  out  32  latched rt_val
mult_out  in  1  multiplier result-valid
mult_hi  in  32  product [63:32]
mult_lo  in  32  product [31:0]

Behaviour:
- Reset (synchronous, any state, including mid-operation): state=IDLE; hi, lo, operand latches, counter = 0; busy, done, div_zero, timeout_err, div_ctrl, mult_ctrl = 0. Unit reset is external; this block guarantees ctrl low from the next cycle.
- States: IDLE, RUN_MULT, RUN_DIV, RELEASE.
- IDLE, op accepted (op_ack=1) at edge N:
  - MULT: latch rs/rt; go RUN_MULT; mult_ctrl=1 from N+1.
  - DIV with rt_val!=0: latch; go RUN_DIV; div_ctrl=1 from N+1.
  - DIV with rt_val==0: stay IDLE; done=div_zero=1 at N+1 only; hi/lo unchanged; div_ctrl never raised.
  - MTHI/MTLO: hi (lo) <= rs_val, visible at N+1; done=1 at N+1; busy stays 0.
- Illegal op_code, or op_valid while busy: ignored, no ack, no state change.
- RUN_x: ctrl held high; operand outputs stable; counter increments each cycle from 0.
  - x_out=1 at edge M: hi/lo <= unit results; ctrl=0, done=1 at M+1; go RELEASE.
  - counter==TIMEOUT-1 without x_out: ctrl=0; timeout_err=1; hi/lo unchanged; no done; go RELEASE.
  - x_out and timeout in the same cycle: completion wins, no error.
- RELEASE: exactly one cycle with both ctrl low so the unit re-arms; busy=1; then IDLE. The earliest next accept is the cycle after RELEASE.
- div_ctrl and mult_ctrl are never high together.
- Counter saturates; no wrap.
- hi/lo change only on MTHI/MTLO, a unit completion, or reset.

Test Plan:
- Reset, then DIV rs=100, rt=7 with divider model asserting div_out after 34 cycles -> busy for 36 cycles; done pulse; hi=2, lo=14; div_ctrl low in RELEASE.
- DIV rs=-7 (0xFFFFFFF9), rt=0 -> no div_ctrl; done=div_zero=1 the next cycle; hi/lo keep prior values; busy never set.
- MTHI rs=0xDEADBEEF, then MTLO rs=0x12345678 in consecutive cycles -> hi, lo updated at N+1, N+2; two done pulses; busy stays 0.
- MULT rs=0x10000, rt=0x10000 with model returning hi=1, lo=0 -> hi=0x1, lo=0x0; op_valid DIV held during RUN gets no op_ack until IDLE.
- Multiplier model never asserts mult_out -> after 64 cycles mult_ctrl drops; timeout_err=1 and sticky; hi/lo unchanged; the next MTHI still works.
- Assert reset at cycle 10 of RUN_DIV -> next cycle all outputs 0, state IDLE; a subsequent DIV 9/3 yields hi=0, lo=3.
